// File: rtl/mem_scan_unit.sv
// Read-only scanner for RAM port B: walks a wrapping address window after a start
// pulse and reports the unsigned sum, maximum value and earliest address of that maximum.
module mem_scan_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int SUM_W  = DATA_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [RD_LAT-1:0] PIPE_ONE  = 1;
    localparam logic [RD_LAT-1:0] LAST_ONLY = PIPE_ONE << (RD_LAT - 1);

    state_t                         state_reg, state_next;
    logic [ADDR_W:0]                rem_reg;
    logic [ADDR_W-1:0]              addr_reg;
    logic                           first_reg;
    logic [SUM_W-1:0]               sum_reg;
    logic [DATA_W-1:0]              max_val_reg;
    logic [ADDR_W-1:0]              max_addr_reg;
    logic [RD_LAT-1:0]              pipe_v_reg, pipe_v_next;
    logic [RD_LAT-1:0][ADDR_W-1:0]  pipe_a_reg, pipe_a_next;

    logic issue_v;
    logic sample_v;
    logic [ADDR_W-1:0] sample_addr;

    assign issue_v     = (state_reg == ISSUE);
    assign sample_v    = pipe_v_reg[RD_LAT-1];
    assign sample_addr = pipe_a_reg[RD_LAT-1];

    // Each stage carries the valid flag and address of one outstanding read.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_v_next[gi] = issue_v;
                assign pipe_a_next[gi] = addr_reg;
            end else begin : g_tail
                assign pipe_v_next[gi] = pipe_v_reg[gi-1];
                assign pipe_a_next[gi] = pipe_a_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            pipe_v_reg <= '0;
            pipe_a_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pipe_v_reg <= pipe_v_next;
            pipe_a_reg <= pipe_a_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = (count == '0) ? DONE : ISSUE;
            ISSUE: if (rem_reg == 1) state_next = DRAIN;
            // In DRAIN nothing new enters the pipe, so a lone top bit is the final sample.
            DRAIN: if (pipe_v_reg == LAST_ONLY) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_reg      <= '0;
            addr_reg     <= '0;
            first_reg    <= 1'b0;
            sum_reg      <= '0;
            max_val_reg  <= '0;
            max_addr_reg <= '0;
        end else begin
            if (state_reg == IDLE && start) begin
                addr_reg     <= base_addr;
                rem_reg      <= count;
                first_reg    <= 1'b1;
                sum_reg      <= '0;
                max_val_reg  <= '0;
                max_addr_reg <= '0;
            end
            if (issue_v) begin
                rem_reg <= rem_reg - 1'b1;
                if (rem_reg != 1) addr_reg <= addr_reg + 1'b1;
            end
            if (sample_v) begin
                sum_reg   <= sum_reg + SUM_W'(doutb);
                first_reg <= 1'b0;
                if (first_reg || doutb > max_val_reg) begin
                    max_val_reg  <= doutb;
                    max_addr_reg <= sample_addr;
                end
            end
        end
    end

    assign addrb    = addr_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign sum      = sum_reg;
    assign max_val  = max_val_reg;
    assign max_addr = max_addr_reg;

endmodule
